// File: rtl/rggen_indirect_array_pkg.sv
// Shared types and constants for the indirect register array window.
package rggen_indirect_array_pkg;

    typedef enum logic {
        IDLE,
        RESPOND
    } state_e;

    localparam logic [1:0] STATUS_OK    = 2'b00;
    localparam logic [1:0] STATUS_ERROR = 2'b10;

endpackage

// File: rtl/rggen_indirect_array_storage.sv
// Entry registers with a masked write port and combinational bus/hardware read ports.
// Unimplemented bits (VALID_BITS = 0) are never written and always read 0.
module rggen_indirect_array_storage #(
    parameter int                    INDEX_WIDTH   = 4,
    parameter int                    DEPTH         = 16,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] VALID_BITS    = '1,
    parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic [DATA_WIDTH-1:0]  write_mask,
    input  logic [INDEX_WIDTH-1:0] read_index,
    output logic [DATA_WIDTH-1:0]  read_data,
    input  logic [INDEX_WIDTH-1:0] hw_index,
    output logic [DATA_WIDTH-1:0]  hw_value
);

    logic [DATA_WIDTH-1:0] entries [DEPTH];
    logic [DATA_WIDTH-1:0] mask;

    assign mask = write_mask & VALID_BITS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= INITIAL_VALUE & VALID_BITS;
            end
        end else if (write_enable) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (write_index == INDEX_WIDTH'(i)) begin
                    entries[i] <= (entries[i] & ~mask) | (write_data & mask);
                end
            end
        end
    end

    // Indexes with no matching entry fall through to zero.
    always_comb begin
        read_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (read_index == INDEX_WIDTH'(i)) begin
                read_data = entries[i] & VALID_BITS;
            end
        end
    end

    always_comb begin
        hw_value = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (hw_index == INDEX_WIDTH'(i)) begin
                hw_value = entries[i] & VALID_BITS;
            end
        end
    end

endmodule

// File: rtl/rggen_indirect_register_array.sv
// Indirect register window over a DEPTH-entry array with request/ready handshake.
// Optional index auto-increment: define RGGEN_INDIRECT_ARRAY_AUTO_INC_EN.
module rggen_indirect_register_array
    import rggen_indirect_array_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
    parameter logic [ADDRESS_WIDTH-1:0] END_ADDRESS   = '0,
    parameter int                       INDEX_WIDTH   = 4,
    parameter int                       DEPTH         = 16,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0]    VALID_BITS    = '1,
    parameter logic [DATA_WIDTH-1:0]    INITIAL_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_request,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic                     i_write,
    input  logic [DATA_WIDTH-1:0]    i_write_data,
    input  logic [DATA_WIDTH-1:0]    i_write_mask,
    input  logic [INDEX_WIDTH-1:0]   i_index,
    output logic                     o_select,
    output logic                     o_ready,
    output logic [DATA_WIDTH-1:0]    o_read_data,
    output logic [1:0]               o_status,
    input  logic [INDEX_WIDTH-1:0]   i_hw_index,
    output logic [DATA_WIDTH-1:0]    o_hw_value
);

    localparam logic [INDEX_WIDTH:0] DEPTH_LIMIT = (INDEX_WIDTH + 1)'(DEPTH);

    state_e                   state;
    state_e                   state_next;
    logic                     accept;
    logic                     in_range;
    logic [INDEX_WIDTH-1:0]   eidx;
    logic [DATA_WIDTH-1:0]    bus_value;
    logic [DATA_WIDTH-1:0]    read_data_q;
    logic [1:0]               status_q;

    // Lower bound compared with a forced-one MSB so a zero START_ADDRESS is not a constant compare.
    assign o_select = ({1'b1, i_address} >= {1'b1, START_ADDRESS}) && (i_address <= END_ADDRESS);
    assign accept   = (state == IDLE) && i_request && o_select;
    assign in_range = {1'b0, eidx} < DEPTH_LIMIT;

`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
    logic [INDEX_WIDTH-1:0] offset;
    logic [INDEX_WIDTH-1:0] prev_index;

    assign eidx = i_index + offset;

    // Any index change restarts the sequence; that takes priority over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset     <= '0;
            prev_index <= '0;
        end else begin
            prev_index <= i_index;
            if (i_index != prev_index) begin
                offset <= '0;
            end else if (accept && in_range) begin
                offset <= offset + INDEX_WIDTH'(1);
            end
        end
    end
`else
    assign eidx = i_index;
`endif

    rggen_indirect_array_storage #(
        .INDEX_WIDTH   (INDEX_WIDTH),
        .DEPTH         (DEPTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .VALID_BITS    (VALID_BITS),
        .INITIAL_VALUE (INITIAL_VALUE)
    ) u_storage (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (accept && i_write && in_range),
        .write_index  (eidx),
        .write_data   (i_write_data),
        .write_mask   (i_write_mask),
        .read_index   (eidx),
        .read_data    (bus_value),
        .hw_index     (i_hw_index),
        .hw_value     (o_hw_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q <= '0;
            status_q    <= STATUS_OK;
        end else if (accept) begin
            read_data_q <= (in_range && !i_write) ? bus_value : '0;
            status_q    <= in_range ? STATUS_OK : STATUS_ERROR;
        end
    end

    always_comb begin
        o_ready     = (state == RESPOND);
        o_read_data = read_data_q;
        o_status    = status_q;
    end

endmodule

// File: tb/tb_rggen_indirect_register_array.sv
// Scoreboard bench: two windows (DEPTH 16 all bits, DEPTH 12 with top nibble unimplemented).
// Auto-increment expectations follow RGGEN_INDIRECT_ARRAY_AUTO_INC_EN.
module tb_rggen_indirect_register_array;

    localparam int          AW     = 16;
    localparam int          IW     = 4;
    localparam int          DW     = 32;
    localparam logic [31:0] VB_A   = 32'hFFFF_FFFF;
    localparam logic [31:0] VB_B   = 32'h0FFF_FFFF;
    localparam logic [31:0] INIT   = 32'hA5A5_0F0F;
    localparam logic [15:0] WSTART = 16'h0040;
    localparam logic [15:0] WEND   = 16'h0043;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  status;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          request = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] write_mask = '0;
    logic [IW-1:0] index = '0;
    logic [IW-1:0] hw_index = '0;

    logic          select_a, ready_a, select_b, ready_b;
    logic [DW-1:0] read_data_a, hw_value_a, read_data_b, hw_value_b;
    logic [1:0]    status_a, status_b;

    resp_t       q_a[$];
    resp_t       q_b[$];
    resp_t       exp_a, exp_b;
    logic [31:0] ma[16];
    logic [31:0] mb[16];
    logic [3:0]  cur_idx;
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
    logic [3:0]  off_a, off_b;
`endif
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rggen_indirect_register_array #(
        .ADDRESS_WIDTH (AW), .START_ADDRESS (WSTART), .END_ADDRESS (WEND),
        .INDEX_WIDTH (IW), .DEPTH (16), .DATA_WIDTH (DW),
        .VALID_BITS (VB_A), .INITIAL_VALUE (INIT)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n), .i_request (request), .i_address (address),
        .i_write (write), .i_write_data (write_data), .i_write_mask (write_mask),
        .i_index (index), .o_select (select_a), .o_ready (ready_a),
        .o_read_data (read_data_a), .o_status (status_a),
        .i_hw_index (hw_index), .o_hw_value (hw_value_a)
    );

    rggen_indirect_register_array #(
        .ADDRESS_WIDTH (AW), .START_ADDRESS (WSTART), .END_ADDRESS (WEND),
        .INDEX_WIDTH (IW), .DEPTH (12), .DATA_WIDTH (DW),
        .VALID_BITS (VB_B), .INITIAL_VALUE (INIT)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n), .i_request (request), .i_address (address),
        .i_write (write), .i_write_data (write_data), .i_write_mask (write_mask),
        .i_index (index), .o_select (select_b), .o_ready (ready_b),
        .o_read_data (read_data_b), .o_status (status_b),
        .i_hw_index (hw_index), .o_hw_value (hw_value_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            ma[i] = INIT & VB_A;
            mb[i] = INIT & VB_B;
        end
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
        off_a = '0;
        off_b = '0;
`endif
    endtask

    task automatic check_hw(input logic [3:0] h);
        hw_index = h;
        #1;
        check("hw_a", hw_value_a, ma[h]);
        check("hw_b", hw_value_b, (h < 4'd12) ? mb[h] : 32'h0);
    endtask

    task automatic check_hw_const(input logic [3:0] h, input logic [31:0] exp);
        hw_index = h;
        #1;
        check("hw_const_a", hw_value_a, exp);
    endtask

    task automatic access(input logic wr, input logic [15:0] addr, input logic [3:0] idx,
                          input logic [31:0] wd, input logic [31:0] wm);
        logic        inwin;
        logic [3:0]  ea, eb;
        logic [31:0] m;
        inwin = (addr >= WSTART) && (addr <= WEND);
        @(posedge clk); #1;
        if (idx != cur_idx) begin
            index   = idx;
            cur_idx = idx;
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
            off_a = '0;
            off_b = '0;
`endif
            @(posedge clk); #1;
        end
        ea = idx;
        eb = idx;
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
        ea = idx + off_a;
        eb = idx + off_b;
`endif
        address = addr; write = wr; write_data = wd; write_mask = wm;
        request = 1'b1;
        hw_index = ea;
        #1;
        check("select_a", 32'(select_a), 32'(inwin));
        check("select_b", 32'(select_b), 32'(inwin));
        if (inwin) begin
            m = wm & VB_A;
            if (wr) begin
                ma[ea] = (ma[ea] & ~m) | (wd & m);
                q_a.push_back('{data: 32'h0, status: 2'b00});
            end else begin
                q_a.push_back('{data: ma[ea], status: 2'b00});
            end
            if (eb >= 4'd12) begin
                q_b.push_back('{data: 32'h0, status: 2'b10});
            end else begin
                m = wm & VB_B;
                if (wr) begin
                    mb[eb] = (mb[eb] & ~m) | (wd & m);
                    q_b.push_back('{data: 32'h0, status: 2'b00});
                end else begin
                    q_b.push_back('{data: mb[eb], status: 2'b00});
                end
            end
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
            off_a = off_a + 4'd1;
            if (eb < 4'd12) off_b = off_b + 4'd1;
`endif
            @(posedge clk); #1;
            check("ready_a_after_accept", 32'(ready_a), 32'd1);
            check("ready_b_after_accept", 32'(ready_b), 32'd1);
            check_hw(ea);
            @(posedge clk); #1;
            check("ready_a_pulse_end", 32'(ready_a), 32'd0);
            check("ready_b_pulse_end", 32'(ready_b), 32'd0);
            request = 1'b0;
        end else begin
            repeat (3) @(posedge clk);
            #1;
            check("ready_a_outside", 32'(ready_a), 32'd0);
            check("ready_b_outside", 32'(ready_b), 32'd0);
            request = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (ready_a) begin
            if (q_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready_a: o_ready 1 required 0 at %0t", $time);
            end else begin
                exp_a = q_a.pop_front();
                check("read_data_a", read_data_a, exp_a.data);
                check("status_a", 32'(status_a), 32'(exp_a.status));
            end
        end
        if (ready_b) begin
            if (q_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready_b: o_ready 1 required 0 at %0t", $time);
            end else begin
                exp_b = q_b.pop_front();
                check("read_data_b", read_data_b, exp_b.data);
                check("status_b", 32'(status_b), 32'(exp_b.status));
            end
        end
    end

    initial begin
        model_reset();
        cur_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready_a), 32'd0);
        check("reset_read_data", read_data_a, 32'h0);
        check("reset_status", 32'(status_a), 32'd0);
        check_hw_const(4'd0, 32'hA5A5_0F0F);
        check("reset_hw_b", hw_value_b, 32'h05A5_0F0F);
        @(negedge clk) rst_n = 1'b1;

        // Full write then read back; END_ADDRESS boundary on the read.
        access(1'b1, 16'h0040, 4'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        check_hw_const(4'd3, 32'hDEAD_BEEF);
        access(1'b0, 16'h0043, 4'd3, 32'h0, 32'h0);

        // Masked write; out-of-window requests just outside both ends are ignored.
        access(1'b1, 16'h0041, 4'd6, 32'h1111_1111, 32'hFFFF_FFFF);
        access(1'b1, 16'h0044, 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        access(1'b1, 16'h003F, 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        access(1'b1, 16'h0040, 4'd6, 32'h0000_FFFF, 32'h0000_FF00);
        check_hw_const(4'd6, 32'h1111_FF11);
        access(1'b0, 16'h0040, 4'd0, 32'h0, 32'h0);
        access(1'b0, 16'h0040, 4'd6, 32'h0, 32'h0);

        // Out-of-range on the 12-entry window; last valid entry.
        access(1'b0, 16'h0040, 4'd13, 32'h0, 32'h0);
        access(1'b1, 16'h0040, 4'd13, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        check("hw_b_out_of_range", 32'(hw_value_b), 32'h0);
        access(1'b0, 16'h0042, 4'd11, 32'h0, 32'h0);

        // Held index.
        for (int k = 0; k < 4; k++) begin
            access(1'b1, 16'h0040, 4'd5, 32'h5000_0000 + 32'(k), 32'hFFFF_FFFF);
        end
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
        check_hw_const(4'd5, 32'h5000_0000);
        check_hw_const(4'd6, 32'h5000_0001);
        check_hw_const(4'd7, 32'h5000_0002);
        check_hw_const(4'd8, 32'h5000_0003);
`else
        check_hw_const(4'd5, 32'h5000_0003);
`endif
        access(1'b1, 16'h0040, 4'd2, 32'h2222_2222, 32'hFFFF_FFFF);
        check_hw_const(4'd2, 32'h2222_2222);
        access(1'b1, 16'h0040, 4'd15, 32'hF0F0_000F, 32'hFFFF_FFFF);
        access(1'b1, 16'h0040, 4'd15, 32'h0F0F_0000, 32'hFFFF_FFFF);
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
        check_hw_const(4'd15, 32'hF0F0_000F);
        check_hw_const(4'd0, 32'h0F0F_0000);
`else
        check_hw_const(4'd15, 32'h0F0F_0000);
`endif

        for (int h = 0; h < 16; h++) begin
            check_hw(4'(h));
        end

        // Reset in the cycle after a write is accepted.
        @(posedge clk); #1;
        index = 4'd9;
        cur_idx = 4'd9;
        @(posedge clk); #1;
        address = 16'h0040; write = 1'b1; write_data = 32'h9999_9999; write_mask = 32'hFFFF_FFFF;
        request = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        request = 1'b0;
        #1;
        check("reset_mid_ready_a", 32'(ready_a), 32'd0);
        check("reset_mid_ready_b", 32'(ready_b), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        check_hw_const(4'd9, 32'hA5A5_0F0F);
        access(1'b0, 16'h0040, 4'd9, 32'h0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("drain_a", 32'(q_a.size()), 32'd0);
        check("drain_b", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
